// File: rtl/fetch_unit_pf.sv
// Pipelined instruction fetch: req/gnt address phase, in-order rvalid responses,
// prefetch FIFO of {instr, pc} drained by decode, redirect flush with stale-response discard.
module fetch_unit_pf #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [31:0]     instr_mem [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];

  logic [CW:0]     credit_sum;
  logic            credit_ok;
  logic            grant;
  logic            push;
  logic            pop;
  logic            drop;
  logic            fifo_nonempty;
  logic [XLEN-1:0] redirect_base;

  // Stale in-flight responses still hold credit, so the sum bounds fetch-ahead distance.
  assign credit_sum    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok     = credit_sum < DEPTH_C;
  assign imem_req      = rst_n & credit_ok & ~redirect_valid;
  assign imem_addr     = fetch_pc;

  assign grant         = imem_req & imem_gnt;
  assign fifo_nonempty = (fifo_count != '0);
  assign drop          = imem_rvalid & ~redirect_valid & (discard != '0);
  assign push          = imem_rvalid & ~redirect_valid & (discard == '0);
  assign pop           = fifo_nonempty & if_ready & ~redirect_valid;
  assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};

  assign if_valid      = fifo_nonempty;
  assign if_instr      = fifo_nonempty ? instr_mem[rd_ptr] : '0;
  assign if_pc         = fifo_nonempty ? pc_mem[rd_ptr] : '0;
  assign if_pc_plus4   = if_pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_VECTOR;
      resp_pc     <= RESET_VECTOR;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc    <= redirect_base;
      resp_pc     <= redirect_base;
      outstanding <= outstanding - CW'(imem_rvalid);
      discard     <= outstanding - CW'(imem_rvalid);
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (grant) fetch_pc <= fetch_pc + XLEN'(4);
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
      if (drop) discard <= discard - CW'(1);
      if (push) begin
        resp_pc <= resp_pc + XLEN'(4);
        wr_ptr  <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit_pf.sv
// Bench for fetch_unit_pf: directed vector table, hand sequences for redirect and
// wrap corners, and a randomized run against a queue-based reference model.
module tb_fetch_unit_pf;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] word_at(logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  fetch_unit_pf #(.XLEN(32), .RESET_VECTOR(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  // Second instance exercising address wrap; its own 1-cycle always-grant memory.
  logic        w_req, w_rvalid, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4;

  fetch_unit_pf #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst_n(rst_n), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .if_valid(w_valid), .if_ready(1'b1), .if_instr(w_instr),
    .if_pc(w_pc), .if_pc_plus4(w_pc4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_rvalid <= 1'b0;
      w_rdata  <= '0;
    end else begin
      w_rvalid <= w_req;
      w_rdata  <= word_at(w_addr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory and reference model state
  typedef struct { logic [31:0] addr; int ep; } mreq_t;
  mreq_t       mem_q[$];
  logic [31:0] fifo_q[$];
  int          epoch;
  logic [31:0] exp_fetch;
  int          mem_mode;
  bit          man_rv;
  bit          model_on;

  logic        s_req, s_gnt, s_rv, s_rdy, s_redir;
  logic [31:0] s_addr, s_rpc;

  task automatic model_check();
    bit exp_req;
    exp_req = rst_n && !redirect_valid && ((mem_q.size() + fifo_q.size()) < DEPTH);
    chk("rnd_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("rnd_addr", imem_addr, exp_fetch);
    chk("rnd_valid", {31'b0, if_valid}, {31'b0, fifo_q.size() > 0});
    if (fifo_q.size() > 0) begin
      chk("rnd_pc", if_pc, fifo_q[0]);
      chk("rnd_instr", if_instr, word_at(fifo_q[0]));
      chk("rnd_pc_plus4", if_pc_plus4, fifo_q[0] + 32'd4);
    end
  endtask

  task automatic settle();
    if (mem_mode == 0)      imem_rvalid = (mem_q.size() > 0);
    else if (mem_mode == 1) imem_rvalid = man_rv && (mem_q.size() > 0);
    else                    imem_rvalid = (mem_q.size() > 0) && ($urandom_range(0, 99) < 60);
    if (imem_rvalid) imem_rdata = word_at(mem_q[0].addr);
    else             imem_rdata = 32'hDEAD_BEEF;
    #1;
    s_req = imem_req; s_gnt = imem_gnt; s_addr = imem_addr; s_rv = imem_rvalid;
    s_rdy = if_ready; s_redir = redirect_valid; s_rpc = redirect_pc;
    if (model_on) model_check();
  endtask

  task automatic advance();
    mreq_t e;
    mreq_t n;
    @(posedge clk);
    if (!s_redir && s_rdy && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (s_rv && mem_q.size() > 0) begin
      e = mem_q.pop_front();
      if (!s_redir && e.ep == epoch) begin
        if (model_on) chk("push_into_full", {31'b0, fifo_q.size() < DEPTH}, 32'd1);
        fifo_q.push_back(e.addr);
      end
    end
    if (s_redir) begin
      epoch++;
      fifo_q.delete();
      exp_fetch = {s_rpc[31:2], 2'b00};
    end else if (s_req && s_gnt) begin
      n.addr = s_addr;
      n.ep = epoch;
      mem_q.push_back(n);
      exp_fetch = exp_fetch + 32'd4;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_gnt = 1'b0;
    if_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_wrap_req", {31'b0, w_req}, 32'd0);
    repeat (2) @(negedge clk);
    mem_q.delete();
    fifo_q.delete();
    epoch = 0;
    exp_fetch = 32'h0;
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      settle();
      if (if_valid) begin
        ok = 1'b1;
        break;
      end
      advance();
    end
  endtask

  typedef struct {
    bit rst; bit rdy; bit gnt;
    bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit rst, bit rdy, bit gnt, bit ereq, logic [31:0] eaddr,
                              bit evalid, logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.gnt = gnt;
    v.e_req = ereq; v.e_addr = eaddr; v.e_valid = evalid; v.e_pc = epc;
    tbl.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    model_on = 1'b0;
    mem_mode = 0;
    man_rv = 1'b0;

    // streaming with ready=1
    add(1,1,1, 1,32'h0, 0,32'h0);
    add(0,1,1, 1,32'h4, 0,32'h0);
    add(0,1,1, 1,32'h8, 1,32'h0);
    add(0,1,1, 1,32'hC, 1,32'h4);
    add(0,1,1, 1,32'h10,1,32'h8);
    add(0,1,1, 1,32'h14,1,32'hC);
    // decode stalled: four grants then credit exhausted, then drain in order
    add(1,0,1, 1,32'h0, 0,32'h0);
    add(0,0,1, 1,32'h4, 0,32'h0);
    add(0,0,1, 1,32'h8, 1,32'h0);
    add(0,0,1, 1,32'hC, 1,32'h0);
    for (int i = 0; i < 6; i++) add(0,0,1, 0,32'h0, 1,32'h0);
    add(0,1,1, 0,32'h0, 1,32'h0);
    add(0,1,1, 1,32'h10,1,32'h4);
    add(0,1,1, 1,32'h14,1,32'h8);
    add(0,1,1, 1,32'h18,1,32'hC);
    add(0,1,1, 1,32'h1C,1,32'h10);
    // grant withheld three cycles: address held
    add(1,1,0, 1,32'h0, 0,32'h0);
    add(0,1,0, 1,32'h0, 0,32'h0);
    add(0,1,0, 1,32'h0, 0,32'h0);
    add(0,1,1, 1,32'h0, 0,32'h0);
    add(0,1,1, 1,32'h4, 0,32'h0);
    add(0,1,1, 1,32'h8, 1,32'h0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      if_ready = tbl[i].rdy;
      imem_gnt = tbl[i].gnt;
      redirect_valid = 1'b0;
      settle();
      chk("tbl_req", {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) chk("tbl_addr", imem_addr, tbl[i].e_addr);
      chk("tbl_valid", {31'b0, if_valid}, {31'b0, tbl[i].e_valid});
      if (tbl[i].e_valid) begin
        chk("tbl_pc", if_pc, tbl[i].e_pc);
        chk("tbl_pc_plus4", if_pc_plus4, tbl[i].e_pc + 32'd4);
        chk("tbl_instr", if_instr, word_at(tbl[i].e_pc));
      end
      advance();
    end

    // redirect to 0x103 with two responses in flight, one returning in the redirect cycle
    do_reset();
    mem_mode = 1;
    if_ready = 1'b1;
    imem_gnt = 1'b1;
    man_rv = 1'b0;
    settle(); chk("redir_a0", imem_addr, 32'h0); advance();
    settle(); chk("redir_a4", imem_addr, 32'h4); advance();
    redirect_valid = 1'b1; redirect_pc = 32'h103; man_rv = 1'b1;
    settle(); chk("redir_req_low", {31'b0, imem_req}, 32'd0); advance();
    redirect_valid = 1'b0;
    settle();
    chk("redir_req_new", {31'b0, imem_req}, 32'd1);
    chk("redir_addr_new", imem_addr, 32'h100);
    chk("redir_flushed", {31'b0, if_valid}, 32'd0);
    advance();
    mem_mode = 0;
    settle(); chk("redir_stale_dropped", {31'b0, if_valid}, 32'd0); advance();
    wait_valid(ok);
    chk("redir_timeout", {31'b0, ok}, 32'd1);
    if (ok) begin
      chk("redir_first_pc", if_pc, 32'h100);
      chk("redir_first_instr", if_instr, word_at(32'h100));
      advance();
    end

    // back-to-back redirects: 0x200 then 0x300
    do_reset();
    mem_mode = 0;
    if_ready = 1'b1;
    imem_gnt = 1'b1;
    repeat (4) begin settle(); advance(); end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    settle(); chk("b2b_req_r1", {31'b0, imem_req}, 32'd0); advance();
    redirect_pc = 32'h300;
    settle(); chk("b2b_req_r2", {31'b0, imem_req}, 32'd0); advance();
    redirect_valid = 1'b0;
    settle();
    chk("b2b_addr", imem_addr, 32'h300);
    chk("b2b_flushed", {31'b0, if_valid}, 32'd0);
    advance();
    wait_valid(ok);
    chk("b2b_timeout", {31'b0, ok}, 32'd1);
    if (ok) begin
      chk("b2b_first_pc", if_pc, 32'h300);
      advance();
      settle();
      chk("b2b_second_valid", {31'b0, if_valid}, 32'd1);
      chk("b2b_second_pc", if_pc, 32'h304);
      advance();
    end

    // wrap instance from reset vector 0xFFFF_FFF8
    do_reset();
    if_ready = 1'b1;
    imem_gnt = 1'b1;
    settle(); chk("wrap_addr0", w_addr, 32'hFFFF_FFF8); chk("wrap_req0", {31'b0, w_req}, 32'd1); advance();
    settle(); chk("wrap_addr1", w_addr, 32'hFFFF_FFFC); advance();
    settle(); chk("wrap_addr2", w_addr, 32'h0); chk("wrap_pc0", w_pc, 32'hFFFF_FFF8); advance();
    settle();
    chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    chk("wrap_pc1_plus4", w_pc4, 32'h0);
    chk("wrap_instr1", w_instr, word_at(32'hFFFF_FFFC));
    advance();
    settle(); chk("wrap_pc2", w_pc, 32'h0); chk("wrap_pc2_plus4", w_pc4, 32'h4); advance();

    // randomized run against the reference model
    do_reset();
    mem_mode = 2;
    model_on = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if_ready = ($urandom_range(0, 99) < 70);
      imem_gnt = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc = $urandom;
      settle();
      advance();
    end
    model_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
